// File: rtl/lift_pkg.sv
// Shared floor constants and scheduler state encoding for the lift control path.
// lift_fsm uses the same floor constants so req_floor/current_floor widths agree.
package lift_pkg;

    localparam int NUM_FLOORS = 8;
    localparam int FLOOR_W    = $clog2(NUM_FLOORS);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SERVE_UP   = 2'd1,
        SERVE_DOWN = 2'd2
    } sched_state_e;

    // One-hot select of a floor, used to clear the floor being served.
    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] floor);
        return NUM_FLOORS'(1) << floor;
    endfunction

endpackage

// File: rtl/lift_floor_picker.sv
// Combinational priority search: nearest pending floor above and below the lift,
// plus whether the lift's own floor is pending.
module lift_floor_picker
    import lift_pkg::*;
(
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic                  above_hit,
    output logic [FLOOR_W-1:0]    above_idx,
    output logic                  below_hit,
    output logic [FLOOR_W-1:0]    below_idx,
    output logic                  at_hit
);

    always_comb begin
        // NOTE: every output gets a default before the loops so no latch is inferred.
        above_hit = 1'b0;
        above_idx = '0;
        below_hit = 1'b0;
        below_idx = '0;

        // Scan downward so the last match left standing is the lowest floor above.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
                above_hit = 1'b1;
                above_idx = FLOOR_W'(i);
            end
        end

        // Scan upward so the last match is the highest floor below.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
                below_hit = 1'b1;
                below_idx = FLOOR_W'(i);
            end
        end

        at_hit = pending[current_floor];
    end

endmodule

// File: rtl/lift_request_scheduler.sv
// SCAN scheduler: accumulates call presses into a pending bitmap and drives the
// next target floor to lift_fsm, sweeping in one direction until it runs dry.
module lift_request_scheduler
    import lift_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    output logic [FLOOR_W-1:0]    req_floor,
    output logic                  req_valid,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  dir_down
);

    sched_state_e          state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
    logic                  req_valid_q, req_valid_d;
    logic                  dir_up_q, dir_up_d;
    logic                  dir_down_q, dir_down_d;

    logic                  above_hit, below_hit, at_hit;
    logic [FLOOR_W-1:0]    above_idx, below_idx;
    logic [NUM_FLOORS-1:0] clr;

    lift_floor_picker u_picker (
        .pending       (pending_q),
        .current_floor (current_floor),
        .above_hit     (above_hit),
        .above_idx     (above_idx),
        .below_hit     (below_hit),
        .below_idx     (below_idx),
        .at_hit        (at_hit)
    );

    // Clear is applied after the OR, so a press at the served floor is dropped.
    always_comb begin
        clr       = door_open ? floor_onehot(current_floor) : '0;
        pending_d = (pending_q | call_btn) & ~clr;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (above_hit)      state_d = SERVE_UP;
                else if (below_hit) state_d = SERVE_DOWN;
                else if (at_hit)    state_d = IDLE;  // door_open at this floor clears it
            end
            SERVE_UP: begin
                if (above_hit)      state_d = SERVE_UP;
                else if (below_hit) state_d = SERVE_DOWN;
                else                state_d = IDLE;
            end
            SERVE_DOWN: begin
                if (below_hit)      state_d = SERVE_DOWN;
                else if (above_hit) state_d = SERVE_UP;
                else                state_d = IDLE;
            end
            default:                state_d = IDLE;
        endcase
    end

    // Outputs are registered alongside the state, reflecting the state being entered.
    always_comb begin
        req_floor_d = current_floor;
        req_valid_d = 1'b0;
        dir_up_d    = (state_d == SERVE_UP);
        dir_down_d  = (state_d == SERVE_DOWN);
        if (state_d == SERVE_UP) begin
            req_floor_d = above_idx;
            req_valid_d = 1'b1;
        end else if (state_d == SERVE_DOWN) begin
            req_floor_d = below_idx;
            req_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            req_floor_q <= '0;
            req_valid_q <= 1'b0;
            dir_up_q    <= 1'b0;
            dir_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            req_floor_q <= req_floor_d;
            req_valid_q <= req_valid_d;
            dir_up_q    <= dir_up_d;
            dir_down_q  <= dir_down_d;
        end
    end

    assign req_floor = req_floor_q;
    assign req_valid = req_valid_q;
    assign pending   = pending_q;
    assign dir_up    = dir_up_q;
    assign dir_down  = dir_down_q;

endmodule

// File: tb/tb_lift_request_scheduler.sv
// Scoreboard bench: stimulus pushes expected snapshots tagged with a cycle number;
// a monitor pops and compares them on the falling edge of that cycle.
module tb_lift_request_scheduler;
    import lift_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_FLOORS-1:0] call_btn;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  door_open;
    logic [FLOOR_W-1:0]    req_floor;
    logic                  req_valid;
    logic [NUM_FLOORS-1:0] pending;
    logic                  dir_up;
    logic                  dir_down;

    lift_request_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .call_btn      (call_btn),
        .current_floor (current_floor),
        .door_open     (door_open),
        .req_floor     (req_floor),
        .req_valid     (req_valid),
        .pending       (pending),
        .dir_up        (dir_up),
        .dir_down      (dir_down)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]           cyc;
        logic [NUM_FLOORS-1:0] pend;
        logic [FLOOR_W-1:0]    rf;
        logic                  rv;
        logic                  up;
        logic                  dn;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Expected outputs as seen after the edge count reached when this is called.
    task automatic expect_now(input string nm, input logic [NUM_FLOORS-1:0] p,
                              input logic [FLOOR_W-1:0] f, input logic v,
                              input logic u, input logic d);
        exp_t e;
        e.cyc  = cyc;
        e.pend = p;
        e.rf   = f;
        e.rv   = v;
        e.up   = u;
        e.dn   = d;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic check(input string nm, input exp_t e);
        total++;
        if (pending !== e.pend || req_floor !== e.rf || req_valid !== e.rv ||
            dir_up !== e.up || dir_down !== e.dn) begin
            bad++;
            $display("FAIL %s: got pend=%h rf=%0d rv=%b up=%b dn=%b want pend=%h rf=%0d rv=%b up=%b dn=%b",
                     nm, pending, req_floor, req_valid, dir_up, dir_down,
                     e.pend, e.rf, e.rv, e.up, e.dn);
        end
    endtask

    initial forever begin
        @(negedge clk);
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
            check(name_q.pop_front(), exp_q.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int wait_cycles;
        rst = 1'b1; call_btn = 8'hFF; current_floor = 3'd0; door_open = 1'b0;
        tick(2);
        expect_now("reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0; call_btn = 8'h00;
        tick(1);

        // Basic serve: call floor 3 from floor 0, then serve it.
        current_floor = 3'd0; call_btn = 8'b0000_1000;
        tick(1); call_btn = 8'h00;
        expect_now("basic_pend", 8'h08, 3'd0, 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_now("basic_target", 8'h08, 3'd3, 1'b1, 1'b1, 1'b0);
        current_floor = 3'd3; door_open = 1'b1;
        tick(1); door_open = 1'b0;
        expect_now("basic_served", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);

        // Preemption: target 6, then floor 4 called while passing floor 2.
        current_floor = 3'd1; call_btn = 8'h40;
        tick(1); call_btn = 8'h00;
        expect_now("pre_pend6", 8'h40, 3'd1, 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_now("pre_target6", 8'h40, 3'd6, 1'b1, 1'b1, 1'b0);
        current_floor = 3'd2; call_btn = 8'h10;
        tick(1); call_btn = 8'h00;
        expect_now("pre_still6", 8'h50, 3'd6, 1'b1, 1'b1, 1'b0);
        tick(1);
        expect_now("pre_target4", 8'h50, 3'd4, 1'b1, 1'b1, 1'b0);
        current_floor = 3'd4; door_open = 1'b1;
        tick(1); door_open = 1'b0;
        expect_now("pre_back6", 8'h40, 3'd6, 1'b1, 1'b1, 1'b0);
        current_floor = 3'd6; door_open = 1'b1;
        tick(1); door_open = 1'b0;
        expect_now("pre_done", 8'h00, 3'd6, 1'b0, 1'b0, 1'b0);

        // Direction hold: going up to 7 from 5, a call at 2 waits for the reversal.
        current_floor = 3'd5; call_btn = 8'h80;
        tick(1); call_btn = 8'h00;
        expect_now("hold_pend7", 8'h80, 3'd5, 1'b0, 1'b0, 1'b0);
        tick(1);
        expect_now("hold_target7", 8'h80, 3'd7, 1'b1, 1'b1, 1'b0);
        call_btn = 8'h04;
        tick(1); call_btn = 8'h00;
        expect_now("hold_call2", 8'h84, 3'd7, 1'b1, 1'b1, 1'b0);
        tick(1);
        expect_now("hold_keep7", 8'h84, 3'd7, 1'b1, 1'b1, 1'b0);
        current_floor = 3'd7; door_open = 1'b1;
        tick(1); door_open = 1'b0;
        expect_now("hold_reverse", 8'h04, 3'd2, 1'b1, 1'b0, 1'b1);

        // Clear wins over a same-cycle press at the served floor.
        current_floor = 3'd3; door_open = 1'b1; call_btn = 8'h08;
        tick(1); door_open = 1'b0; call_btn = 8'h00;
        expect_now("simul_drop", 8'h04, 3'd2, 1'b1, 1'b0, 1'b1);
        tick(1);
        expect_now("simul_stay", 8'h04, 3'd2, 1'b1, 1'b0, 1'b1);

        // Reset mid-operation with pending 8'h44.
        call_btn = 8'h40;
        tick(1); call_btn = 8'h00;
        expect_now("mid_pend44", 8'h44, 3'd2, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick(1); rst = 1'b0;
        expect_now("mid_reset", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        tick(3);
        expect_now("mid_no_resume", 8'h00, 3'd3, 1'b0, 1'b0, 1'b0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            tick(1);
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lift_request_scheduler.md
Name: lift_request_scheduler

Overview:
Upstream stage of lift_fsm. Latches per-floor call-button presses into a pending-request register and picks the next target floor with a SCAN (elevator) policy. Drives lift_fsm's req_floor. Clears a floor's request when the lift is at that floor with its door open.

Parameters:
NUM_FLOORS, 8, number of served floors (0..NUM_FLOORS-1)
FLOOR_W, 3, floor index width; must equal clog2(NUM_FLOORS) and match lift_fsm current_floor/req_floor

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
call_btn  input  NUM_FLOORS  call request per floor; a press may be a single-cycle pulse or a level; OR-accumulated
current_floor  input  FLOOR_W  floor position reported by lift_fsm
door_open  input  1  lift_fsm door_open; marks the current floor as served
req_floor  output  FLOOR_W  target floor to lift_fsm (registered)
req_valid  output  1  1 while a target is being served (registered)
pending  output  NUM_FLOORS  outstanding request bitmap (registered)
dir_up  output  1  scheduler state is SERVE_UP (registered)
dir_down  output  1  scheduler state is SERVE_DOWN (registered)

Behaviour:
- Reset (rst=1 at clk edge):
  - pending=0, state=IDLE
  - req_floor=0, req_valid=0, dir_up=0, dir_down=0
  - Reset mid-operation discards all pending requests; no partial state survives.
- Pending update each edge: pending <= (pending | call_btn) & ~clr.
  - clr = onehot(current_floor) when door_open=1; otherwise 0.
  - A call at the served floor in the same cycle as door_open is dropped; clear wins.
- Search: lift_floor_picker compares pending (registered) against current_floor.
  - above_hit/above_idx: lowest pending index > current_floor.
  - below_hit/below_idx: highest pending index < current_floor.
  - at_hit: pending[current_floor].
- State machine: IDLE, SERVE_UP, SERVE_DOWN.
  - IDLE:
    - above_hit -> SERVE_UP; else below_hit -> SERVE_DOWN; else stay.
    - Outputs: req_valid=0, req_floor=current_floor.
    - An at_hit-only request is cleared by door_open without leaving IDLE.
  - SERVE_UP:
    - above_hit -> stay; req_floor=above_idx, req_valid=1.
    - Else below_hit -> SERVE_DOWN; else -> IDLE.
  - SERVE_DOWN: mirror of SERVE_UP, using below_idx.
- Target is re-evaluated every cycle. A new call between current_floor and the target, in the direction of travel, preempts the target. Calls behind the direction of travel wait until the sweep reverses.
- Latency:
  - call_btn at edge N -> pending bit set after edge N.
  - req_floor/req_valid/dir_* update after edge N+1.
- Boundaries:
  - current_floor = NUM_FLOORS-1: above_hit=0.
  - current_floor = 0: below_hit=0.
  - pending=0 in SERVE_* -> IDLE next edge.
- All arithmetic is unsigned, FLOOR_W bits. No wrap-around: floor indices never increment past NUM_FLOORS-1.

Decomposition:
- Package lift_pkg holds NUM_FLOORS, FLOOR_W, and the state enum (IDLE, SERVE_UP, SERVE_DOWN). lift_fsm shares the floor constants.
- Sub-module lift_floor_picker: purely combinational nearest-above/nearest-below priority search.
- The top block holds only the pending register, the FSM and the output registers.

Test Plan:
- Reset: rst=1 for 2 cycles, call_btn=8'hFF -> pending=0, req_valid=0, req_floor=0, dir_up=dir_down=0.
- Basic serve:
  - current_floor=0; pulse call_btn=8'b0000_1000 -> pending=8'h08 next cycle; req_floor=3, req_valid=1, dir_up=1 one cycle later.
  - Then current_floor=3, door_open=1 -> pending=0, state IDLE, req_valid=0.
- Preemption: current_floor=1, call floor 6 -> req_floor=6; at current_floor=2, call floor 4 -> req_floor=4 two cycles later; after floor 4 is served -> req_floor=6.
- Direction hold:
  - current_floor=5 in SERVE_UP with target 7; call floor 2 -> req_floor stays 7.
  - Serve floor 7 (door_open) -> dir_down=1, req_floor=2.
- Simultaneous: current_floor=3, door_open=1, call_btn[3]=1 same cycle -> pending[3]=0 afterward.
- Reset mid-operation: pending=8'h44 while serving floor 2; pulse rst -> pending=0, req_valid=0, req_floor=0, dir_*=0; no request resumes afterward.
